// File: rtl/exec_datapath_unit_if.sv
// rtl/exec_datapath_unit_if.sv - operand/control inputs and result/flag outputs of the execute slice
interface exec_datapath_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   logic [DATA_W-1:0] pc_in;
   logic [ADDR_W-1:0] addr_field;
   logic [DATA_W-1:0] reg_a;
   logic [DATA_W-1:0] reg_b;
   logic [5:0]        alu_control;
   logic              flags_we;
   logic [DATA_W-1:0] add_1_out;
   logic [DATA_W-1:0] adress_extend_out;
   logic [DATA_W-1:0] alu_result;
   logic [5:0]        alu_flags;
   logic [5:0]        flags;

   modport master (
      output pc_in, addr_field, reg_a, reg_b, alu_control, flags_we,
      input  add_1_out, adress_extend_out, alu_result, alu_flags, flags
   );

   modport slave (
      input  pc_in, addr_field, reg_a, reg_b, alu_control, flags_we,
      output add_1_out, adress_extend_out, alu_result, alu_flags, flags
   );
endinterface

// File: rtl/exec_datapath_unit.sv
// rtl/exec_datapath_unit.sv - PC incrementer, jump-target extender, ALU and flags register (opcode 0x10 MUL under ALU_MUL_EN)
module exec_datapath_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
) (
   input  logic                clk,
   input  logic                reset,
   exec_datapath_unit_if.slave bus
);
   localparam logic [5:0] OP_ADD  = 6'h00;
   localparam logic [5:0] OP_SUB  = 6'h01;
   localparam logic [5:0] OP_AND  = 6'h02;
   localparam logic [5:0] OP_OR   = 6'h03;
   localparam logic [5:0] OP_XOR  = 6'h04;
   localparam logic [5:0] OP_NOT  = 6'h05;
   localparam logic [5:0] OP_NOR  = 6'h06;
   localparam logic [5:0] OP_NAND = 6'h07;
   localparam logic [5:0] OP_SLL  = 6'h08;
   localparam logic [5:0] OP_SRL  = 6'h09;
   localparam logic [5:0] OP_SRA  = 6'h0A;
   localparam logic [5:0] OP_INC  = 6'h0B;
   localparam logic [5:0] OP_DEC  = 6'h0C;
   localparam logic [5:0] OP_PASA = 6'h0D;
   localparam logic [5:0] OP_PASB = 6'h0E;
   localparam logic [5:0] OP_SLT  = 6'h0F;
`ifdef ALU_MUL_EN
   localparam logic [5:0] OP_MUL  = 6'h10;
`endif
   localparam int MSB = DATA_W - 1;

   logic [DATA_W-1:0] w_add_b;
   logic              w_add_cin;
   logic [DATA_W:0]   w_add_full;
   logic              w_add_v;
   logic [4:0]        w_shamt;
   logic [DATA_W-1:0] w_result;
   logic              w_c;
   logic              w_v;
   logic              w_z;
   logic [5:0]        w_alu_flags;
   logic [5:0]        r_flags;

   assign bus.add_1_out         = bus.pc_in + {{(DATA_W-1){1'b0}}, 1'b1};
   assign bus.adress_extend_out = {{(DATA_W-ADDR_W){1'b0}}, bus.addr_field};

   // One shared adder: subtract-style ops feed ~B (or ~1) with carry-in so C means "no borrow"
   always_comb begin
      w_add_b   = bus.reg_b;
      w_add_cin = 1'b0;
      case (bus.alu_control)
         OP_SUB, OP_SLT: begin
            w_add_b   = ~bus.reg_b;
            w_add_cin = 1'b1;
         end
         OP_INC:  w_add_b = {{(DATA_W-1){1'b0}}, 1'b1};
         OP_DEC: begin
            w_add_b   = ~{{(DATA_W-1){1'b0}}, 1'b1};
            w_add_cin = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_add_full = {1'b0, bus.reg_a} + {1'b0, w_add_b} + {{DATA_W{1'b0}}, w_add_cin};
   assign w_add_v    = (bus.reg_a[MSB] == w_add_b[MSB]) && (w_add_full[MSB] != bus.reg_a[MSB]);
   assign w_shamt    = bus.reg_b[4:0];

   // Operation select; C and V only come from the arithmetic ops, everything else leaves them 0
   always_comb begin
      w_result = '0;
      w_c      = 1'b0;
      w_v      = 1'b0;
      case (bus.alu_control)
         OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            w_result = w_add_full[MSB:0];
            w_c      = w_add_full[DATA_W];
            w_v      = w_add_v;
         end
         OP_AND:  w_result = bus.reg_a & bus.reg_b;
         OP_OR:   w_result = bus.reg_a | bus.reg_b;
         OP_XOR:  w_result = bus.reg_a ^ bus.reg_b;
         OP_NOT:  w_result = ~bus.reg_a;
         OP_NOR:  w_result = ~(bus.reg_a | bus.reg_b);
         OP_NAND: w_result = ~(bus.reg_a & bus.reg_b);
         OP_SLL:  w_result = bus.reg_a << w_shamt;
         OP_SRL:  w_result = bus.reg_a >> w_shamt;
         OP_SRA:  w_result = $signed(bus.reg_a) >>> w_shamt;
         OP_PASA: w_result = bus.reg_a;
         OP_PASB: w_result = bus.reg_b;
         OP_SLT: begin
            // signed less-than is the sign of A-B corrected by overflow
            w_result = {{(DATA_W-1){1'b0}}, w_add_full[MSB] ^ w_add_v};
            w_c      = w_add_full[DATA_W];
         end
`ifdef ALU_MUL_EN
         OP_MUL:  w_result = bus.reg_a * bus.reg_b;
`endif
         default: ;
      endcase
   end

   assign w_z         = (w_result == '0);
   assign w_alu_flags = {^w_result, !w_z && !w_result[MSB], w_v, w_c, w_result[MSB], w_z};
   assign bus.alu_result = w_result;
   assign bus.alu_flags  = w_alu_flags;

   // Flags register: async clear wins over a simultaneous enabled load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= 6'b0;
      end else if (bus.flags_we) begin
         r_flags <= w_alu_flags;
      end
   end

   assign bus.flags = r_flags;
endmodule

// File: tb/tb_exec_datapath_unit.sv
// tb/tb_exec_datapath_unit.sv - vector table, random model comparison and flags-register sequences
module tb_exec_datapath_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   exec_datapath_unit_if #(.DATA_W(32), .ADDR_W(12)) bus ();

   exec_datapath_unit #(.DATA_W(32), .ADDR_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [5:0]  fl;
   } vec_t;

   vec_t        vecs[12];
   logic [31:0] special[6];
   logic [5:0]  exp_reg;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // flags[5:0] = {PAR, P, V, C, N, Z}, result in low 32 bits
   function automatic logic [37:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint ua, ub, sa, sb, t;
      logic [31:0] r;
      logic c, v;
      int sh;
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sh = int'(b[4:0]);
      r = 32'b0; c = 1'b0; v = 1'b0;
      case (op)
         6'h00: begin t = ua + ub; r = t[31:0]; c = t[32]; t = sa + sb; v = (t > MAXS) || (t < MINS); end
         6'h01: begin r = a - b; c = (ua >= ub); t = sa - sb; v = (t > MAXS) || (t < MINS); end
         6'h02: r = a & b;
         6'h03: r = a | b;
         6'h04: r = a ^ b;
         6'h05: r = ~a;
         6'h06: r = ~(a | b);
         6'h07: r = ~(a & b);
         6'h08: begin t = ua << sh; r = t[31:0]; end
         6'h09: begin t = ua >> sh; r = t[31:0]; end
         6'h0A: begin t = sa >>> sh; r = t[31:0]; end
         6'h0B: begin t = ua + 1; r = t[31:0]; c = t[32]; v = (sa + 1) > MAXS; end
         6'h0C: begin r = a - 32'd1; c = (ua >= 1); v = (sa - 1) < MINS; end
         6'h0D: r = a;
         6'h0E: r = b;
         6'h0F: begin r = (sa < sb) ? 32'd1 : 32'd0; c = (ua >= ub); end
`ifdef ALU_MUL_EN
         6'h10: begin t = ua * ub; r = t[31:0]; end
`endif
         default: ;
      endcase
      return {^r, (r != 32'b0) && !r[31], v, c, r[31], r == 32'b0, r};
   endfunction

   initial begin
      logic [37:0] m;
      vecs[0]  = '{6'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 6'b101010};
      vecs[1]  = '{6'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 6'b000101};
      vecs[2]  = '{6'h01, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 6'b000101};
      vecs[3]  = '{6'h0F, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 6'b110100};
      vecs[4]  = '{6'h0A, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 6'b100010};
      vecs[5]  = '{6'h10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 6'b000001};
      vecs[6]  = '{6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 6'b000001};
      vecs[7]  = '{6'h08, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 6'b110000};
      vecs[8]  = '{6'h09, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001, 6'b000010};
      vecs[9]  = '{6'h0C, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 6'b000010};
      vecs[10] = '{6'h0B, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 6'b101010};
      vecs[11] = '{6'h00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 6'b010000};
      special = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};

      bus.pc_in = 32'h5; bus.addr_field = 12'hFFF; bus.reg_a = 32'h0; bus.reg_b = 32'h0;
      bus.alu_control = 6'h0; bus.flags_we = 1'b0;
      #1;
      check("reset_flags", {26'b0, bus.flags}, 32'h0);
      check("inc_5", bus.add_1_out, 32'h6);
      check("ext_fff", bus.adress_extend_out, 32'h0000_0FFF);
      bus.pc_in = 32'hFFFF_FFFF;
      #1;
      check("inc_wrap", bus.add_1_out, 32'h0);

      @(negedge clk);
      reset = 1'b1;
      exp_reg = 6'b0;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.alu_control = vecs[i].op; bus.reg_a = vecs[i].a; bus.reg_b = vecs[i].b;
         #1;
         check($sformatf("vec%0d_res", i), bus.alu_result, vecs[i].res);
         check($sformatf("vec%0d_flags", i), {26'b0, bus.alu_flags}, {26'b0, vecs[i].fl});
      end

      // flags register load/hold
      @(negedge clk);
      bus.alu_control = 6'h00; bus.reg_a = 32'd2; bus.reg_b = 32'd3; bus.flags_we = 1'b1;
      @(posedge clk); #1;
      check("flags_load", {26'b0, bus.flags}, 32'b010000);
      @(negedge clk);
      bus.alu_control = 6'h01; bus.reg_a = 32'd5; bus.reg_b = 32'd5; bus.flags_we = 1'b0;
      @(posedge clk); #1;
      check("flags_hold", {26'b0, bus.flags}, 32'b010000);

      // async reset mid-cycle, and priority over flags_we
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("flags_async_clr", {26'b0, bus.flags}, 32'h0);
      check("comb_in_reset", bus.alu_result, 32'h0);
      check("comb_flags_in_reset", {26'b0, bus.alu_flags}, 32'b000101);
      bus.flags_we = 1'b1;
      @(posedge clk); #1;
      check("reset_priority", {26'b0, bus.flags}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      bus.flags_we = 1'b0;
      exp_reg = 6'b0;

      // random operations against the model, including the flags register
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         bus.alu_control = 6'($urandom_range(0, 20));
         bus.reg_a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
         bus.reg_b = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 2) == 0) bus.reg_b = 32'($urandom_range(0, 40));
         bus.pc_in = $urandom;
         bus.addr_field = 12'($urandom);
         bus.flags_we = 1'($urandom_range(0, 1));
         m = model(bus.alu_control, bus.reg_a, bus.reg_b);
         #1;
         check("rnd_res", bus.alu_result, m[31:0]);
         check("rnd_flags", {26'b0, bus.alu_flags}, {26'b0, m[37:32]});
         check("rnd_inc", bus.add_1_out, bus.pc_in + 32'd1);
         check("rnd_ext", bus.adress_extend_out, {20'b0, bus.addr_field});
         if (bus.flags_we) exp_reg = m[37:32];
         @(posedge clk); #1;
         check("rnd_flags_reg", {26'b0, bus.flags}, {26'b0, exp_reg});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
